// File: rtl/seg_memory_access.sv
// seg_memory_access: MEM stage of the 5-stage MIPS pipeline.
// Runs loads/stores against an external data RAM over a req/ack handshake,
// stalls upstream while an access is pending and registers results into
// the MEM/WB boundary.
// Ports: i_clk/i_rst (async, active-high); execute-stage inputs i_valid,
// i_ALU_result, i_write_data, i_write_register, i_ctrl_wb_bus, i_ctrl_mem_bus;
// RAM side o_mem_req/we/addr/wdata/be with i_mem_ack/i_mem_rdata;
// o_stall to upstream; MEM/WB outputs o_valid, o_read_data, o_ALU_result,
// o_write_register, o_ctrl_wb_bus, o_misaligned, o_mem_err.
// Optional feature: define MEM_TIMEOUT_EN to enable the ack watchdog.
module seg_memory_access #(
    parameter int LEN            = 32,
    parameter int NB_ADDR        = 5,
    parameter int NB_CTRL_WB     = 2,
    parameter int NB_CTRL_M      = 9,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [LEN-1:0]        i_ALU_result,
    input  logic [LEN-1:0]        i_write_data,
    input  logic [NB_ADDR-1:0]    i_write_register,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
    input  logic                  i_mem_ack,
    input  logic [LEN-1:0]        i_mem_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [LEN-1:0]        o_mem_addr,
    output logic [LEN-1:0]        o_mem_wdata,
    output logic [3:0]            o_mem_be,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [LEN-1:0]        o_read_data,
    output logic [LEN-1:0]        o_ALU_result,
    output logic [NB_ADDR-1:0]    o_write_register,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
    output logic                  o_misaligned,
    output logic                  o_mem_err
);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [LEN-1:0]        addr_q, addr_d;
    logic [LEN-1:0]        wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  valid_q, valid_d;
    logic [LEN-1:0]        rdata_q, rdata_d;
    logic [LEN-1:0]        alu_q, alu_d;
    logic [NB_ADDR-1:0]    wreg_q, wreg_d;
    logic [NB_CTRL_WB-1:0] wb_q, wb_d;
    logic                  mis_q, mis_d;
    logic                  err_d;

    logic       mem_rd, mem_wr, is_uns, memop, aligned, start, misaligned;
    logic       is_load, abort;
    logic [1:0] size, lane;
    logic [3:0]     be_calc;
    logic [LEN-1:0] wdata_calc, ld_data;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;

    assign mem_rd  = i_ctrl_mem_bus[6];
    assign mem_wr  = i_ctrl_mem_bus[5];
    assign size    = i_ctrl_mem_bus[4:3];
    assign is_uns  = i_ctrl_mem_bus[2];
    assign lane    = i_ALU_result[1:0];
    assign memop   = i_valid & (mem_rd | mem_wr);
    // Store wins when both MemRead and MemWrite are set.
    assign is_load = mem_rd & ~mem_wr;

    always_comb begin
        aligned = 1'b1;
        if (size[1])
            aligned = (lane == 2'b00);
        else if (size[0])
            aligned = ~lane[0];
    end

    assign start      = memop & aligned;
    assign misaligned = memop & ~aligned;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = i_write_data;
        if (!size[1]) begin
            if (size[0]) begin
                be_calc    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{i_write_data[15:0]}};
            end else begin
                be_calc    = 4'b0001 << lane;
                wdata_calc = {4{i_write_data[7:0]}};
            end
        end
    end

    assign ld_byte = i_mem_rdata[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        ld_data = i_mem_rdata;
        if (!size[1]) begin
            if (size[0])
                ld_data = {{16{~is_uns & ld_half[15]}}, ld_half};
            else
                ld_data = {{24{~is_uns & ld_byte[7]}}, ld_byte};
        end
    end

    logic unused_ok;
    assign unused_ok = ^{i_ctrl_mem_bus[NB_CTRL_M-1:7],
                         i_ctrl_mem_bus[1:0]};

`ifdef MEM_TIMEOUT_EN
    localparam int NB_CNT = $clog2(TIMEOUT_CYCLES + 1);

    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic              err_q;

    // Abort in the TIMEOUT_CYCLES-th ACCESS cycle that sees no ack.
    assign abort = (state_q == S_ACCESS) & ~i_mem_ack &
                   (cnt_q == NB_CNT'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE)
            cnt_d = '0;
        else if (!i_mem_ack && !abort)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_mem_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign abort     = 1'b0;
    assign o_mem_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        alu_d   = alu_q;
        wreg_d  = wreg_q;
        wb_d    = wb_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        o_stall = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    o_stall = 1'b1;
                    state_d = S_ACCESS;
                    req_d   = 1'b1;
                    we_d    = mem_wr;
                    addr_d  = {i_ALU_result[LEN-1:2], 2'b00};
                    wdata_d = wdata_calc;
                    be_d    = be_calc;
                end else begin
                    // Plain ops, bubbles and misaligned faults all pass
                    // through in one cycle; stray acks are ignored here.
                    valid_d = i_valid;
                    alu_d   = i_ALU_result;
                    wreg_d  = i_write_register;
                    wb_d    = misaligned ? '0 : i_ctrl_wb_bus;
                    rdata_d = '0;
                    mis_d   = misaligned;
                end
            end
            S_ACCESS: begin
                if (i_mem_ack || abort) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    alu_d   = i_ALU_result;
                    wreg_d  = i_write_register;
                    wb_d    = abort ? '0 : i_ctrl_wb_bus;
                    rdata_d = (is_load && !abort) ? ld_data : '0;
                    err_d   = abort;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            alu_q   <= '0;
            wreg_q  <= '0;
            wb_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            wreg_q  <= wreg_d;
            wb_q    <= wb_d;
            mis_q   <= mis_d;
        end
    end

    assign o_mem_req        = req_q;
    assign o_mem_we         = we_q;
    assign o_mem_addr       = addr_q;
    assign o_mem_wdata      = wdata_q;
    assign o_mem_be         = be_q;
    assign o_valid          = valid_q;
    assign o_read_data      = rdata_q;
    assign o_ALU_result     = alu_q;
    assign o_write_register = wreg_q;
    assign o_ctrl_wb_bus    = wb_q;
    assign o_misaligned     = mis_q;

endmodule

// File: tb/tb_seg_memory_access.sv
// tb_seg_memory_access: directed bench for the MEM stage.
// Table of single transactions plus hand sequences for reset and timeout.
module tb_seg_memory_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_alu = '0;
    logic [31:0] i_wdata = '0;
    logic [4:0]  i_wreg = '0;
    logic [1:0]  i_wb = '0;
    logic [8:0]  i_ctrl = '0;
    logic        i_ack = 1'b0;
    logic [31:0] i_rdata = '0;

    logic        o_mem_req, o_mem_we, o_stall, o_valid;
    logic        o_misaligned, o_mem_err;
    logic [31:0] o_mem_addr, o_mem_wdata, o_read_data, o_alu;
    logic [3:0]  o_mem_be;
    logic [4:0]  o_wreg;
    logic [1:0]  o_wb;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg_memory_access dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_valid          (i_valid),
        .i_ALU_result     (i_alu),
        .i_write_data     (i_wdata),
        .i_write_register (i_wreg),
        .i_ctrl_wb_bus    (i_wb),
        .i_ctrl_mem_bus   (i_ctrl),
        .i_mem_ack        (i_ack),
        .i_mem_rdata      (i_rdata),
        .o_mem_req        (o_mem_req),
        .o_mem_we         (o_mem_we),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .o_mem_be         (o_mem_be),
        .o_stall          (o_stall),
        .o_valid          (o_valid),
        .o_read_data      (o_read_data),
        .o_ALU_result     (o_alu),
        .o_write_register (o_wreg),
        .o_ctrl_wb_bus    (o_wb),
        .o_misaligned     (o_misaligned),
        .o_mem_err        (o_mem_err)
    );

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic [1:0]  wb;
        logic [8:0]  ctrl;
        int          delay;
        logic [31:0] rdata;
        logic        req;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic        ovalid;
        logic [31:0] rd;
        logic        mis;
        logic [1:0]  owb;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [8:0] c(input logic rd, input logic wr,
                                     input logic [1:0] sz, input logic uns);
        return {2'b00, rd, wr, sz, uns, 2'b00};
    endfunction

    function automatic vec_t mk(
        input logic v, input logic [31:0] a, input logic [31:0] wd,
        input logic [4:0] wr, input logic [1:0] wb, input logic [8:0] ct,
        input int dl, input logic [31:0] rdt, input logic rq,
        input logic we, input logic [31:0] ma, input logic [3:0] be,
        input logic [31:0] mwd, input logic ov, input logic [31:0] rd,
        input logic mis, input logic [1:0] owb);
        vec_t r;
        r.valid = v;  r.addr = a;   r.wdata = wd;  r.wreg = wr;
        r.wb = wb;    r.ctrl = ct;  r.delay = dl;  r.rdata = rdt;
        r.req = rq;   r.we = we;    r.maddr = ma;  r.be = be;
        r.mwdata = mwd; r.ovalid = ov; r.rd = rd;  r.mis = mis;
        r.owb = owb;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        i_valid = v.valid;
        i_alu   = v.addr;
        i_wdata = v.wdata;
        i_wreg  = v.wreg;
        i_wb    = v.wb;
        i_ctrl  = v.ctrl;
        i_ack   = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(v);
        #1;
        chk({t, ".stall0"}, 32'(o_stall), 32'(v.req));
        if (v.req) begin
            @(negedge clk);
            chk({t, ".req"}, 32'(o_mem_req), 32'd1);
            chk({t, ".we"}, 32'(o_mem_we), 32'(v.we));
            chk({t, ".maddr"}, o_mem_addr, v.maddr);
            chk({t, ".be"}, 32'(o_mem_be), 32'(v.be));
            if (v.we)
                chk({t, ".mwdata"}, o_mem_wdata, v.mwdata);
            chk({t, ".stall1"}, 32'(o_stall), 32'd1);
            for (int k = 1; k < v.delay; k++)
                @(negedge clk);
            i_ack   = 1'b1;
            i_rdata = v.rdata;
            #1;
            chk({t, ".stall_ack"}, 32'(o_stall), 32'd0);
        end
        @(negedge clk);
        i_ack = 1'b0;
        chk({t, ".req_done"}, 32'(o_mem_req), 32'd0);
        chk({t, ".valid"}, 32'(o_valid), 32'(v.ovalid));
        chk({t, ".rdata"}, o_read_data, v.rd);
        chk({t, ".alu"}, o_alu, v.addr);
        chk({t, ".wreg"}, 32'(o_wreg), 32'(v.wreg));
        chk({t, ".wb"}, 32'(o_wb), 32'(v.owb));
        chk({t, ".mis"}, 32'(o_misaligned), 32'(v.mis));
        chk({t, ".err"}, 32'(o_mem_err), 32'd0);
        i_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h1234, 0, 5, 2'b11, c(0,0,2'b00,0), 0, 0,
                      0, 0, 0, 4'b0000, 0, 1, 0, 0, 2'b11);
        vecs[1]  = mk(1, 32'h13, 32'h11223344, 6, 2'b01, c(1,0,2'b00,0),
                      3, 32'h80FF_0000,
                      1, 0, 32'h10, 4'b1000, 0, 1, 32'hFFFF_FF80, 0, 2'b01);
        vecs[2]  = mk(1, 32'h13, 32'h11223344, 7, 2'b01, c(1,0,2'b00,1),
                      1, 32'h80FF_0000,
                      1, 0, 32'h10, 4'b1000, 0, 1, 32'h0000_0080, 0, 2'b01);
        vecs[3]  = mk(1, 32'h102, 32'hAAAA_BEEF, 0, 2'b00, c(0,1,2'b01,0),
                      2, 0,
                      1, 1, 32'h100, 4'b1100, 32'hBEEF_BEEF, 1, 0, 0, 2'b00);
        vecs[4]  = mk(1, 32'h2, 0, 8, 2'b11, c(1,0,2'b10,0), 0, 0,
                      0, 0, 0, 4'b0000, 0, 1, 0, 1, 2'b00);
        vecs[5]  = mk(1, 32'h6, 0, 9, 2'b01, c(1,0,2'b01,0), 1, 32'h8001_7FFF,
                      1, 0, 32'h4, 4'b1100, 0, 1, 32'hFFFF_8001, 0, 2'b01);
        vecs[6]  = mk(1, 32'h20, 0, 10, 2'b01, c(1,0,2'b10,0), 1,
                      32'hDEAD_BEEF,
                      1, 0, 32'h20, 4'b1111, 0, 1, 32'hDEAD_BEEF, 0, 2'b01);
        vecs[7]  = mk(1, 32'h41, 32'h0000_00A5, 0, 2'b10, c(0,1,2'b00,0),
                      1, 0,
                      1, 1, 32'h40, 4'b0010, 32'hA5A5_A5A5, 1, 0, 0, 2'b10);
        vecs[8]  = mk(1, 32'h50, 32'h1234_5678, 0, 2'b10, c(1,1,2'b10,0),
                      1, 32'hFFFF_FFFF,
                      1, 1, 32'h50, 4'b1111, 32'h1234_5678, 1, 0, 0, 2'b10);
        vecs[9]  = mk(1, 32'h3, 0, 11, 2'b01, c(1,0,2'b01,1), 0, 0,
                      0, 0, 0, 4'b0000, 0, 1, 0, 1, 2'b00);
        vecs[10] = mk(0, 32'h44, 0, 3, 2'b11, c(1,0,2'b10,0), 0, 0,
                      0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b11);
        vecs[11] = mk(1, 32'h2, 0, 4, 2'b01, c(1,0,2'b01,1), 2, 32'hFFFF_1234,
                      1, 0, 32'h0, 4'b1100, 0, 1, 32'h0000_FFFF, 0, 2'b01);

        // Reset state
        @(negedge clk);
        #1;
        chk("rst.req", 32'(o_mem_req), 32'd0);
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.stall", 32'(o_stall), 32'd0);
        chk("rst.rdata", o_read_data, 32'd0);
        chk("rst.alu", o_alu, 32'd0);
        chk("rst.be", 32'(o_mem_be), 32'd0);
        chk("rst.err", 32'(o_mem_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_vec(i, vecs[i]);

        // Ack while idle must be ignored
        @(negedge clk);
        drive(vecs[0]);
        i_ack   = 1'b1;
        i_rdata = 32'hCAFE_F00D;
        #1;
        chk("idle_ack.stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        i_ack = 1'b0;
        i_valid = 1'b0;
        chk("idle_ack.req", 32'(o_mem_req), 32'd0);
        chk("idle_ack.valid", 32'(o_valid), 32'd1);
        chk("idle_ack.rdata", o_read_data, 32'd0);

        // Reset pulsed in the middle of an access
        @(negedge clk);
        drive(vecs[6]);
        @(negedge clk);
        chk("rst_mid.req_before", 32'(o_mem_req), 32'd1);
        rst = 1'b1;
        i_valid = 1'b0;
        #1;
        chk("rst_mid.req", 32'(o_mem_req), 32'd0);
        chk("rst_mid.valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(100, vecs[6]);

`ifdef MEM_TIMEOUT_EN
        // Watchdog aborts after 16 ack-less ACCESS cycles
        @(negedge clk);
        drive(vecs[6]);
        @(negedge clk);
        for (int k = 1; k < 16; k++)
            @(negedge clk);
        #1;
        chk("tmo.req_held", 32'(o_mem_req), 32'd1);
        chk("tmo.stall_abort", 32'(o_stall), 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        chk("tmo.err", 32'(o_mem_err), 32'd1);
        chk("tmo.valid", 32'(o_valid), 32'd1);
        chk("tmo.req", 32'(o_mem_req), 32'd0);
        chk("tmo.wb", 32'(o_wb), 32'd0);
        @(negedge clk);
        chk("tmo.err_pulse", 32'(o_mem_err), 32'd0);
`else
        // Without the watchdog the access waits as long as it takes
        @(negedge clk);
        drive(vecs[6]);
        @(negedge clk);
        for (int k = 1; k < 20; k++)
            @(negedge clk);
        #1;
        chk("wait.req_held", 32'(o_mem_req), 32'd1);
        chk("wait.stall", 32'(o_stall), 32'd1);
        chk("wait.err", 32'(o_mem_err), 32'd0);
        i_ack   = 1'b1;
        i_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        i_ack = 1'b0;
        i_valid = 1'b0;
        chk("wait.valid", 32'(o_valid), 32'd1);
        chk("wait.rdata", o_read_data, 32'h0BAD_F00D);
        chk("wait.req", 32'(o_mem_req), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
